// File: rtl/ace_snap_loader.sv
// ace_snap_loader: streams a .ace snapshot into the Jupiter Ace loader port.
// Optional RLE decoding (ED n v runs, ED 00 end marker) when ACE_LOADER_RLE_EN is defined.
module ace_snap_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h2000,
    parameter logic [15:0] END_ADDR  = 16'h7FFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        loader_en,
    output logic [15:0] loader_addr,
    output logic [7:0]  loader_data,
    output logic        loader_wr,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    localparam logic [7:0] ESC_BYTE = 8'hED;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_TRN  = 2'b10;

`ifdef ACE_LOADER_RLE_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_LIT,
        S_ESC,
        S_CNT,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_LIT,
        S_DONE,
        S_ERR
    } state_t;
`endif

    state_t      r_state;
    logic [16:0] r_cnt;
    logic        r_en;
    logic [15:0] r_addr;
    logic [7:0]  r_data;
    logic        r_wr;
    logic        r_done;
    logic [1:0]  r_err;
`ifdef ACE_LOADER_RLE_EN
    logic [7:0]  r_rem;
    logic [7:0]  r_val;
`endif

    logic        w_ready;
    logic        w_acc;
    logic        w_ovf;

    // Byte acceptance depends only on registered state, never on in_* directly.
`ifdef ACE_LOADER_RLE_EN
    assign w_ready = (r_state == S_LIT) ||
                     (r_state == S_ESC) ||
                     (r_state == S_CNT);
`else
    assign w_ready = (r_state == S_LIT);
`endif

    assign w_acc = in_valid & w_ready;

    // The 17-bit counter lets END_ADDR = FFFF still detect running past the top.
    assign w_ovf = (r_cnt > {1'b0, END_ADDR});

    // Main sequencer: decoding, write strobes and sticky status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= {1'b0, BASE_ADDR};
            r_en    <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_data  <= 8'h00;
            r_wr    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 2'b00;
`ifdef ACE_LOADER_RLE_EN
            r_rem   <= 8'h00;
            r_val   <= 8'h00;
`endif
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LIT;
                        r_en    <= 1'b1;
                        r_done  <= 1'b0;
                        r_err   <= 2'b00;
                        r_cnt   <= {1'b0, BASE_ADDR};
                        r_addr  <= BASE_ADDR;
                    end
                end
                S_LIT: begin
                    if (w_acc) begin
`ifdef ACE_LOADER_RLE_EN
                        if (in_data == ESC_BYTE) begin
                            if (in_last) begin
                                r_err   <= ERR_TRN;
                                r_en    <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_ESC;
                            end
                        end else if (w_ovf) begin
`else
                        if (w_ovf) begin
`endif
                            r_err   <= ERR_OVF;
                            r_en    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_wr   <= 1'b1;
                            r_addr <= r_cnt[15:0];
                            r_data <= in_data;
                            r_cnt  <= r_cnt + 17'd1;
                            if (in_last) begin
`ifdef ACE_LOADER_RLE_EN
                                r_state <= S_ERR;
`else
                                r_state <= S_DONE;
`endif
                            end
                        end
                    end
                end
`ifdef ACE_LOADER_RLE_EN
                S_ESC: begin
                    if (w_acc) begin
                        if (in_data == 8'h00) begin
                            r_done  <= 1'b1;
                            r_en    <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (in_last) begin
                            r_err   <= ERR_TRN;
                            r_en    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_rem   <= in_data;
                            r_state <= S_CNT;
                        end
                    end
                end
                S_CNT: begin
                    if (w_acc) begin
                        if (in_last) begin
                            r_err   <= ERR_TRN;
                            r_en    <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (w_ovf) begin
                            r_err   <= ERR_OVF;
                            r_en    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_wr    <= 1'b1;
                            r_addr  <= r_cnt[15:0];
                            r_data  <= in_data;
                            r_val   <= in_data;
                            r_cnt   <= r_cnt + 17'd1;
                            r_rem   <= r_rem - 8'd1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (r_rem == 8'h00) begin
                        r_state <= S_LIT;
                    end else if (w_ovf) begin
                        r_err   <= ERR_OVF;
                        r_en    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wr   <= 1'b1;
                        r_addr <= r_cnt[15:0];
                        r_data <= r_val;
                        r_cnt  <= r_cnt + 17'd1;
                        r_rem  <= r_rem - 8'd1;
                    end
                end
`endif
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_en    <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_err   <= ERR_TRN;
                    r_en    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_en    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = w_ready;
    assign loader_en   = r_en;
    assign busy        = r_en;
    assign loader_addr = r_addr;
    assign loader_data = r_data;
    assign loader_wr   = r_wr;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_ace_snap_loader.sv
// tb_ace_snap_loader: directed streams checked against a stream-level decoder model.
// Covers ACE_LOADER_RLE_EN defined or undefined, matching the RTL build.
module tb_ace_snap_loader;

    localparam logic [15:0] BASE = 16'h2000;
    localparam logic [15:0] ENDA = 16'h2003;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        loader_en;
    logic [15:0] loader_addr;
    logic [7:0]  loader_data;
    logic        loader_wr;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    ace_snap_loader #(.BASE_ADDR(BASE), .END_ADDR(ENDA)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .loader_en(loader_en),
        .loader_addr(loader_addr), .loader_data(loader_data),
        .loader_wr(loader_wr), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] exp_q[$];
    logic [7:0]  stim[$];
    logic [1:0]  m_err;
    logic        m_done;
    logic [15:0] m_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Decoder model: derives the write list and final status from the stream.
    task automatic model(input bit use_last);
        int unsigned a;
        int L;
        logic [7:0] n;
        logic [7:0] v;
        int i;
        a = BASE;
        L = stim.size() - 1;
        i = 0;
        exp_q.delete();
        m_err = 2'b00;
        m_done = 1'b0;
        m_addr = BASE;
        while (i <= L) begin
`ifdef ACE_LOADER_RLE_EN
            if (stim[i] == 8'hED) begin
                if (use_last && i == L) begin m_err = 2'b10; return; end
                n = stim[i+1];
                if (n == 8'h00) begin m_done = 1'b1; return; end
                if (use_last && i + 1 == L) begin m_err = 2'b10; return; end
                if (use_last && i + 2 == L) begin m_err = 2'b10; return; end
                v = stim[i+2];
                for (int k = 0; k < int'(n); k++) begin
                    if (a > ENDA) begin m_err = 2'b01; return; end
                    exp_q.push_back({a[15:0], v});
                    m_addr = a[15:0];
                    a++;
                end
                i += 3;
                continue;
            end
`endif
            if (a > ENDA) begin m_err = 2'b01; return; end
            exp_q.push_back({a[15:0], stim[i]});
            m_addr = a[15:0];
            a++;
            if (use_last && i == L) begin
`ifdef ACE_LOADER_RLE_EN
                m_err = 2'b10;
`else
                m_done = 1'b1;
`endif
                return;
            end
            i++;
        end
    endtask

    // Every write strobe must match the next write the model predicted.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("busy_eq_en", {31'd0, busy}, {31'd0, loader_en});
            if (loader_wr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {8'd0, loader_addr, loader_data}, 32'hFFFFFFFF);
                end else begin
                    chk("write", {8'd0, loader_addr, loader_data}, {8'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("en_after_start", {31'd0, loader_en}, 32'd1);
        chk("rdy_after_start", {31'd0, in_ready}, 32'd1);
        chk("done_cleared", {31'd0, done}, 32'd0);
        chk("err_cleared", {30'd0, err}, 32'd0);
    endtask

    task automatic send(input logic [7:0] b, input bit last);
        int n;
        n = 0;
        in_data = b;
        in_valid = 1'b1;
        in_last = last;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic finish_check(input string nm);
        int n;
        n = 0;
        while (loader_en && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_en_low"}, {31'd0, loader_en}, 32'd0);
        chk({nm, "_done"}, {31'd0, done}, {31'd0, m_done});
        chk({nm, "_err"}, {30'd0, err}, {30'd0, m_err});
        chk({nm, "_addr"}, {16'd0, loader_addr}, {16'd0, m_addr});
        chk({nm, "_rdy_low"}, {31'd0, in_ready}, 32'd0);
        chk({nm, "_all_writes"}, exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_load(input string nm, input bit use_last);
        model(use_last);
        do_start();
        for (int i = 0; i < stim.size(); i++) begin
            send(stim[i], use_last && (i == stim.size() - 1));
        end
        finish_check(nm);
    endtask

    task automatic reset_check();
        chk("rst_en", {31'd0, loader_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr", {31'd0, loader_wr}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd0);
        chk("rst_addr", {16'd0, loader_addr}, {16'd0, BASE});
        chk("rst_data", {24'd0, loader_data}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        in_data = 8'h00;
        in_valid = 1'b0;
        in_last = 1'b0;
        #12;
        reset_check();
        reset_n = 1'b1;
        @(posedge clk); #1;

`ifdef ACE_LOADER_RLE_EN
        // Literals, with an ignored start and an idle gap mid-stream.
        stim = '{8'h11, 8'h22, 8'h33, 8'hED, 8'h00};
        model(1'b1);
        chk("pin_lit_n", exp_q.size(), 32'd3);
        chk("pin_lit_w2", {8'd0, exp_q[2]}, 32'h00200233);
        chk("pin_lit_done", {31'd0, m_done}, 32'd1);
        do_start();
        send(8'h11, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy_en", {31'd0, loader_en}, 32'd1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'hED, 1'b0);
        send(8'h00, 1'b1);
        chk("lit_en_drop", {31'd0, loader_en}, 32'd0);
        chk("lit_done_now", {31'd0, done}, 32'd1);
        finish_check("lit");

        // Run of four AA on consecutive cycles.
        stim = '{8'hED, 8'h04, 8'hAA, 8'hED, 8'h00};
        model(1'b1);
        chk("pin_run_w3", {8'd0, exp_q[3]}, 32'h002003AA);
        do_start();
        send(8'hED, 1'b0);
        send(8'h04, 1'b0);
        send(8'hAA, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("run_wr", {31'd0, loader_wr}, 32'd1);
            chk("run_rdy_low", {31'd0, in_ready}, 32'd0);
            chk("run_addr", {16'd0, loader_addr}, 32'h2000 + k);
            @(posedge clk); #1;
        end
        chk("run_rdy_back", {31'd0, in_ready}, 32'd1);
        send(8'hED, 1'b0);
        send(8'h00, 1'b1);
        finish_check("run");

        stim = '{8'hED, 8'h01, 8'hED, 8'h5A, 8'hED, 8'h00};
        model(1'b1);
        chk("pin_esc_w0", {8'd0, exp_q[0]}, 32'h002000ED);
        run_load("esc_ed", 1'b1);

        stim = '{8'hED, 8'h08, 8'hFF};
        model(1'b0);
        chk("pin_ovf_err", {30'd0, m_err}, 32'd1);
        chk("pin_ovf_n", exp_q.size(), 32'd4);
        run_load("ovf", 1'b0);

        stim = '{8'h44};
        model(1'b1);
        do_start();
        send(8'h44, 1'b1);
        chk("trn_wr", {31'd0, loader_wr}, 32'd1);
        chk("trn_en_still", {31'd0, loader_en}, 32'd1);
        @(posedge clk); #1;
        chk("trn_err_now", {30'd0, err}, 32'd2);
        finish_check("trn_lit");

        stim = '{8'hED, 8'h03};
        run_load("trn_esc", 1'b1);

        stim = '{8'hED, 8'h02, 8'h66};
        run_load("trn_cnt", 1'b1);

        stim = '{8'hED, 8'h08, 8'h55};
`else
        stim = '{8'hED, 8'h00, 8'h77};
        model(1'b1);
        chk("pin_off_n", exp_q.size(), 32'd3);
        chk("pin_off_w1", {8'd0, exp_q[1]}, 32'h00200100);
        chk("pin_off_done", {31'd0, m_done}, 32'd1);
        run_load("verbatim", 1'b1);

        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        model(1'b0);
        chk("pin_off_ovf", {30'd0, m_err}, 32'd1);
        run_load("ovf", 1'b0);

        stim = '{8'h9C};
        run_load("single", 1'b1);

        stim = '{8'hA1, 8'hA2, 8'hA3};
`endif
        // Asynchronous reset in the middle of a load.
        model(1'b0);
        do_start();
        for (int i = 0; i < stim.size(); i++) send(stim[i], 1'b0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        reset_check();
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        stim = '{8'h12, 8'h34, 8'hED, 8'h00};
        run_load("after_rst", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
